evm_multi: RTL and testbench

EVM_MULTI -- requirements
Module: evm_multi

---
 rtl/evm_multi_if.sv | 26 ++
 rtl/evm_multi.sv | 244 ++++++++++++++++++++++++
 tb/tb_evm_multi.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/evm_multi_if.sv
// Voting-machine pin bundle: poll-officer and candidate buttons in, status and tallies out.
// The master side is the panel driving buttons; the slave side is the evm_multi core.
interface evm_multi_if #(
   parameter int NUM_CAND = 4,
   parameter int DIGITS   = 3
);
   logic                         admin;
   logic [NUM_CAND-1:0]          cand;
   logic                         ready;
   logic [NUM_CAND-1:0]          vote_led;
   logic                         invalid;
   logic                         sat;
   logic [NUM_CAND*DIGITS*4-1:0] tally;
   logic [2:0]                   leader;
   logic                         tie;

   modport master (
      output admin, cand,
      input  ready, vote_led, invalid, sat, tally, leader, tie
   );

   modport slave (
      input  admin, cand,
      output ready, vote_led, invalid, sat, tally, leader, tie
   );
endinterface

// File: rtl/evm_multi.sv
// evm_multi: multi-candidate electronic voting machine with BCD tallies.
// A rising edge on admin arms one ballot; exactly one candidate press then
// records it. Tallies saturate at all nines. Leader/tie are registered.
// Optional build macro EVM_TIMEOUT_EN adds a ballot-expiry counter (TIMEOUT).
module evm_multi #(
   parameter int NUM_CAND = 4,
   parameter int DIGITS   = 3
`ifdef EVM_TIMEOUT_EN
   ,
   parameter int TIMEOUT  = 255
`endif
) (
   input  logic       clk,
   input  logic       reset,
   evm_multi_if.slave bus
);

   localparam int TW = DIGITS * 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_RECORD = 2'd2
   } state_t;

   // BCD +1 with ripple carry; an all-nines value is returned unchanged
   function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v);
      logic [TW-1:0] res;
      logic          carry;
      res   = v;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (res[d*4 +: 4] == 4'd9) begin
               res[d*4 +: 4] = 4'd0;
            end else begin
               res[d*4 +: 4] = res[d*4 +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end else begin
            res[d*4 +: 4] = res[d*4 +: 4];
         end
      end
      return carry ? v : res;
   endfunction

   // True when every digit holds 9, i.e. the tally is at its ceiling
   function automatic logic all_nines(input logic [TW-1:0] v);
      logic r;
      r = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         r = r & (v[d*4 +: 4] == 4'd9);
      end
      return r;
   endfunction

   state_t              r_state;
   state_t              w_state_next;
   logic                r_admin_prev;
   logic [NUM_CAND-1:0] r_cand_prev;
   logic [2:0]          r_sel;
   logic [2:0]          w_sel_next;
   logic                r_ready;
   logic                r_invalid;
   logic                w_invalid_next;
   logic [NUM_CAND-1:0] r_vote_led;
   logic                r_sat;
   logic [2:0]          r_leader;
   logic                r_tie;
   logic [TW-1:0]       r_tally [NUM_CAND];

   logic                w_admin_edge;
   logic [NUM_CAND-1:0] w_cand_edge;
   logic [3:0]          w_edge_cnt;
   logic [2:0]          w_edge_idx;
   logic                w_tmo_hit;
   logic [TW-1:0]       w_tally_sel;
   logic [TW-1:0]       w_tally_inc;
   logic [TW-1:0]       w_max;
   logic [2:0]          w_lead;
   logic [3:0]          w_max_cnt;

   assign w_admin_edge = bus.admin & ~r_admin_prev;
   assign w_cand_edge  = bus.cand & ~r_cand_prev;

   // previous-value copies of the buttons for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_admin_prev <= 1'b0;
         r_cand_prev  <= '0;
      end else begin
         r_admin_prev <= bus.admin;
         r_cand_prev  <= bus.cand;
      end
   end

   // count simultaneous candidate edges and remember which one fired
   always_comb begin
      w_edge_cnt = 4'd0;
      w_edge_idx = 3'd0;
      for (int i = 0; i < NUM_CAND; i++) begin
         w_edge_cnt = w_edge_cnt + {3'd0, w_cand_edge[i]};
         w_edge_idx = w_cand_edge[i] ? 3'(i) : w_edge_idx;
      end
   end

`ifdef EVM_TIMEOUT_EN
   logic [15:0] r_tmo_cnt;

   // cycles spent armed; zero in the first armed cycle of every ballot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tmo_cnt <= 16'd0;
      end else if (r_state != ST_ARMED) begin
         r_tmo_cnt <= 16'd0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
   end

   assign w_tmo_hit = (r_tmo_cnt == 16'(TIMEOUT - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   // next-state, latched candidate and invalid-press decode
   always_comb begin
      w_state_next   = r_state;
      w_sel_next     = r_sel;
      w_invalid_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_admin_edge) begin
               w_state_next = ST_ARMED;       // a simultaneous vote is ignored
            end else if (w_edge_cnt != 4'd0) begin
               w_invalid_next = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (w_edge_cnt == 4'd1) begin
               w_state_next = ST_RECORD;
               w_sel_next   = w_edge_idx;
            end else if (w_tmo_hit) begin
               w_state_next   = ST_IDLE;
               w_invalid_next = 1'b1;
            end else if (w_edge_cnt != 4'd0) begin
               w_invalid_next = 1'b1;         // ballot kept for a retry
            end else begin
               w_state_next = ST_ARMED;       // admin edges do not stack
            end
         end
         ST_RECORD: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // FSM state and its registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_sel      <= 3'd0;
         r_ready    <= 1'b0;
         r_invalid  <= 1'b0;
         r_vote_led <= '0;
      end else begin
         r_state    <= w_state_next;
         r_sel      <= w_sel_next;
         r_ready    <= (w_state_next == ST_ARMED);
         r_invalid  <= w_invalid_next;
         r_vote_led <= (r_state == ST_RECORD) ? (NUM_CAND'(1) << r_sel) : '0;
      end
   end

   // select the latched candidate's tally and form its saturating increment
   always_comb begin
      w_tally_sel = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         w_tally_sel = (r_sel == 3'(i)) ? r_tally[i] : w_tally_sel;
      end
      w_tally_inc = bcd_inc(w_tally_sel);
   end

   // commit the vote in RECORD; saturation flag is sticky until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CAND; i++) begin
            r_tally[i] <= '0;
         end
         r_sat <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if ((r_state == ST_RECORD) && (r_sel == 3'(i))) begin
               r_tally[i] <= w_tally_inc;
            end else begin
               r_tally[i] <= r_tally[i];
            end
         end
         r_sat <= r_sat | ((r_state == ST_RECORD) && all_nines(w_tally_inc));
      end
   end

   // highest tally (lowest index on ties) and how many share it
   always_comb begin
      w_max     = r_tally[0];
      w_lead    = 3'd0;
      w_max_cnt = 4'd0;
      for (int i = 1; i < NUM_CAND; i++) begin
         w_lead = (r_tally[i] > w_max) ? 3'(i) : w_lead;
         w_max  = (r_tally[i] > w_max) ? r_tally[i] : w_max;
      end
      for (int i = 0; i < NUM_CAND; i++) begin
         w_max_cnt = w_max_cnt + {3'd0, (r_tally[i] == w_max)};
      end
   end

   // register leader/tie one cycle behind the tallies
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_leader <= 3'd0;
         r_tie    <= 1'b0;
      end else begin
         r_leader <= w_lead;
         r_tie    <= (w_max_cnt >= 4'd2) && (w_max != '0);
      end
   end

   for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_tally_out
      assign bus.tally[gi*TW +: TW] = r_tally[gi];
   end

   assign bus.ready    = r_ready;
   assign bus.invalid  = r_invalid;
   assign bus.vote_led = r_vote_led;
   assign bus.sat      = r_sat;
   assign bus.leader   = r_leader;
   assign bus.tie      = r_tie;

endmodule

// File: tb/tb_evm_multi.sv
// Directed self-checking bench for evm_multi (NUM_CAND=4, DIGITS=3).
// With EVM_TIMEOUT_EN defined the DUT is built with TIMEOUT=10.
module tb_evm_multi;

   logic clk = 1'b0;
   logic reset;
   int   n_asserts = 0;
   int   n_fail    = 0;

   always #5 clk = ~clk;

   evm_multi_if #(.NUM_CAND(4), .DIGITS(3)) bus ();

   evm_multi #(
      .NUM_CAND(4),
      .DIGITS(3)
`ifdef EVM_TIMEOUT_EN
      ,
      .TIMEOUT(10)
`endif
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] tal(input int i);
      return bus.tally[i*12 +: 12];
   endfunction

   // full ballot: arm, press one candidate, wait until the tally commits
   task automatic do_vote(input int c);
      bus.admin = 1'b1;
      tick();
      bus.admin = 1'b0;
      bus.cand  = 4'b0001 << c;
      tick();
      bus.cand  = 4'b0000;
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      bus.admin = 1'b0;
      bus.cand  = 4'b0000;
      #12;
      chk("rst_ready",   64'(bus.ready),    64'd0);
      chk("rst_tally",   64'(bus.tally),    64'd0);
      chk("rst_vled",    64'(bus.vote_led), 64'd0);
      chk("rst_invalid", 64'(bus.invalid),  64'd0);
      chk("rst_sat",     64'(bus.sat),      64'd0);
      chk("rst_leader",  64'(bus.leader),   64'd0);
      chk("rst_tie",     64'(bus.tie),      64'd0);
      tick();
      reset = 1'b0;
      tick();

      // basic ballot for candidate 0
      bus.admin = 1'b1;
      tick();
      chk("b0_ready_arm", 64'(bus.ready), 64'd1);
      bus.admin = 1'b0;
      bus.cand  = 4'b0001;
      tick();
      chk("b0_ready_rec", 64'(bus.ready), 64'd0);
      chk("b0_t0_pre",    64'(tal(0)),    64'h000);
      bus.cand = 4'b0000;
      tick();
      chk("b0_t0",   64'(tal(0)),       64'h001);
      chk("b0_vled", 64'(bus.vote_led), 64'b0001);
      tick();
      chk("b0_vled_off", 64'(bus.vote_led), 64'b0000);
      chk("b0_leader",   64'(bus.leader),   64'd0);
      chk("b0_tie",      64'(bus.tie),      64'd0);

      // double press while armed keeps the ballot
      bus.admin = 1'b1;
      tick();
      bus.admin = 1'b0;
      bus.cand  = 4'b0011;
      tick();
      chk("dbl_invalid", 64'(bus.invalid), 64'd1);
      chk("dbl_ready",   64'(bus.ready),   64'd1);
      bus.cand = 4'b0000;
      tick();
      chk("dbl_invalid_off", 64'(bus.invalid), 64'd0);
      chk("dbl_t0",          64'(tal(0)),      64'h001);
      chk("dbl_t1_pre",      64'(tal(1)),      64'h000);
      bus.cand = 4'b0010;
      tick();
      bus.cand = 4'b0000;
      tick();
      chk("dbl_t1",   64'(tal(1)),       64'h001);
      chk("dbl_vled", 64'(bus.vote_led), 64'b0010);

      // press while idle is rejected
      bus.cand = 4'b0100;
      tick();
      chk("idle_invalid", 64'(bus.invalid), 64'd1);
      chk("idle_ready",   64'(bus.ready),   64'd0);
      bus.cand = 4'b0000;
      tick();
      chk("idle_invalid_off", 64'(bus.invalid), 64'd0);
      chk("idle_t2",          64'(tal(2)),      64'h000);
      chk("tie01_leader",     64'(bus.leader),  64'd0);
      chk("tie01_tie",        64'(bus.tie),     64'd1);

      // admin and cand together arm only; a second admin does not stack
      bus.admin = 1'b1;
      bus.cand  = 4'b0001;
      tick();
      chk("same_ready",   64'(bus.ready),   64'd1);
      chk("same_invalid", 64'(bus.invalid), 64'd0);
      bus.admin = 1'b0;
      bus.cand  = 4'b0000;
      tick();
      chk("same_t0", 64'(tal(0)), 64'h001);
      bus.admin = 1'b1;
      tick();
      bus.admin = 1'b0;
      tick();
      chk("stack_ready", 64'(bus.ready), 64'd1);
      bus.cand = 4'b0001;
      tick();
      bus.cand = 4'b0000;
      tick();
      chk("stack_t0", 64'(tal(0)), 64'h002);
      tick();
      chk("stack_ready_off", 64'(bus.ready),  64'd0);
      chk("stack_leader",    64'(bus.leader), 64'd0);
      chk("stack_tie",       64'(bus.tie),    64'd0);

      // asynchronous reset clears tallies without a clock edge
      #2;
      reset = 1'b1;
      #1;
      chk("arst_tally", 64'(bus.tally), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      // leader and tie tracking
      do_vote(1);
      do_vote(2);
      tick();
      chk("lt_leader1", 64'(bus.leader), 64'd1);
      chk("lt_tie1",    64'(bus.tie),    64'd1);
      do_vote(2);
      chk("lt_t2", 64'(tal(2)), 64'h002);
      tick();
      chk("lt_leader2", 64'(bus.leader), 64'd2);
      chk("lt_tie2",    64'(bus.tie),    64'd0);
      chk("lt_sat",     64'(bus.sat),    64'd0);

      // fill candidate 3 to 999, then one more ballot saturates
      for (int k = 0; k < 999; k++) begin
         do_vote(3);
      end
      chk("sat_t3_999", 64'(tal(3)), 64'h999);
      tick();
      chk("sat_leader", 64'(bus.leader), 64'd3);
      do_vote(3);
      chk("sat_t3_hold", 64'(tal(3)),       64'h999);
      chk("sat_flag",    64'(bus.sat),      64'd1);
      chk("sat_vled",    64'(bus.vote_led), 64'b1000);
      chk("sat_ready",   64'(bus.ready),    64'd0);
      tick();
      chk("sat_vled_off", 64'(bus.vote_led), 64'b0000);

      // reset during RECORD loses the pending vote
      bus.admin = 1'b1;
      tick();
      bus.admin = 1'b0;
      bus.cand  = 4'b0001;
      tick();
      bus.cand  = 4'b0000;
      bus.admin = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("rrec_tally",  64'(bus.tally),  64'd0);
      chk("rrec_ready",  64'(bus.ready),  64'd0);
      chk("rrec_sat",    64'(bus.sat),    64'd0);
      chk("rrec_leader", 64'(bus.leader), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // admin held through reset counts as an edge on the first clock
      tick();
      chk("held_ready", 64'(bus.ready), 64'd1);
      bus.admin = 1'b0;

`ifdef EVM_TIMEOUT_EN
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("tmo_wait_ready",   64'(bus.ready),   64'd1);
         chk("tmo_wait_invalid", 64'(bus.invalid), 64'd0);
      end
      tick();
      chk("tmo_ready",   64'(bus.ready),   64'd0);
      chk("tmo_invalid", 64'(bus.invalid), 64'd1);
      tick();
      chk("tmo_invalid_off", 64'(bus.invalid), 64'd0);
`else
      for (int k = 0; k < 20; k++) begin
         tick();
      end
      chk("persist_ready",   64'(bus.ready),   64'd1);
      chk("persist_invalid", 64'(bus.invalid), 64'd0);
      bus.cand = 4'b0001;
      tick();
      bus.cand = 4'b0000;
      tick();
      chk("persist_t0", 64'(tal(0)), 64'h001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
